// File: rtl/seq_datapath.sv
// Shared-bus CPU datapath: register bank, special registers, I/O ports and a sequenced ALU
// with iterative signed multiply/divide. Optional ALU_FLAGS_EN adds registered flag_z/flag_n outputs.
module seq_datapath #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = $clog2(NUM_REGS + 7),
  parameter int RSEL_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [SEL_W-1:0]  bus_sel,
  input  logic              ba_out,
  input  logic              reg_wr,
  input  logic [RSEL_W-1:0] reg_wr_sel,
  input  logic              y_in,
  input  logic              hi_in,
  input  logic              lo_in,
  input  logic              pc_in,
  input  logic              out_in,
  input  logic              mdr_in,
  input  logic              mdr_read,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              in_strobe,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        alu_op,
  input  logic              alu_start,
  output logic              alu_busy,
  output logic              alu_done,
  output logic [DATA_W-1:0] bus_out,
`ifdef ALU_FLAGS_EN
  output logic              flag_z,
  output logic              flag_n,
`endif
  output logic [DATA_W-1:0] out_data
);

  // state | meaning
  // IDLE  | waiting for alu_start; single-cycle ops complete here
  // ITER  | one shift-add / shift-subtract step per cycle
  // FIX   | apply signs, write Z pair
  typedef enum logic [1:0] {IDLE, ITER, FIX} aluStateT;

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [SEL_W-1:0] SEL_HI  = SEL_W'(NUM_REGS);
  localparam logic [SEL_W-1:0] SEL_LO  = SEL_W'(NUM_REGS + 1);
  localparam logic [SEL_W-1:0] SEL_ZHI = SEL_W'(NUM_REGS + 2);
  localparam logic [SEL_W-1:0] SEL_ZLO = SEL_W'(NUM_REGS + 3);
  localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(NUM_REGS + 4);
  localparam logic [SEL_W-1:0] SEL_MDR = SEL_W'(NUM_REGS + 5);
  localparam logic [SEL_W-1:0] SEL_IN  = SEL_W'(NUM_REGS + 6);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] hiReg, loReg, pcReg, mdrReg, yReg, zHi, zLo, inPort, busVal;

  aluStateT state, nextState;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] accHi, accLo, opB;
  logic mulOp, resNeg, remNeg, divZero;
  logic accept, finish, isMulOp, isDivOp, aNeg, bNeg;
  logic [DATA_W-1:0] magA, magB, simpleRes, rotR, rotL, fixHi, fixLo;
  logic [SH_W-1:0] shAmt;
  logic [DATA_W:0] mulSum, remShift, diff;
  logic [2*DATA_W-1:0] mulSigned;

  always_comb begin
    busVal = '0;
    case (bus_sel)
      SEL_HI:  busVal = hiReg;
      SEL_LO:  busVal = loReg;
      SEL_ZHI: busVal = zHi;
      SEL_ZLO: busVal = zLo;
      SEL_PC:  busVal = pcReg;
      SEL_MDR: busVal = mdrReg;
      SEL_IN:  busVal = inPort;
      default: if (bus_sel < SEL_W'(NUM_REGS) && !(ba_out && bus_sel == '0))
                 busVal = regs[bus_sel[RSEL_W-1:0]];
    endcase
  end
  assign bus_out = busVal;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      hiReg <= '0; loReg <= '0; pcReg <= '0; mdrReg <= '0;
      yReg <= '0; inPort <= '0; out_data <= '0;
    end else begin
      if (reg_wr)    regs[reg_wr_sel] <= busVal;
      if (hi_in)     hiReg <= busVal;
      if (lo_in)     loReg <= busVal;
      if (pc_in)     pcReg <= busVal;
      if (y_in)      yReg <= busVal;
      if (out_in)    out_data <= busVal;
      if (mdr_in)    mdrReg <= mdr_read ? mem_data_in : busVal;
      if (in_strobe) inPort <= in_data;
    end
  end

  // Single-cycle results come straight from Y and the live bus
  assign shAmt = busVal[SH_W-1:0];
  assign rotR  = DATA_W'({yReg, yReg} >> shAmt);
  assign rotL  = DATA_W'(({yReg, yReg} << shAmt) >> DATA_W);

  always_comb begin
    simpleRes = '0;
    case (alu_op)
      4'd0: simpleRes = yReg + busVal;
      4'd1: simpleRes = yReg - busVal;
      4'd2: simpleRes = yReg & busVal;
      4'd3: simpleRes = yReg | busVal;
      4'd4: simpleRes = yReg >> shAmt;
      4'd5: simpleRes = yReg << shAmt;
      4'd6: simpleRes = rotR;
      4'd7: simpleRes = rotL;
      4'd8: simpleRes = -busVal;
      4'd9: simpleRes = ~busVal;
      default: simpleRes = '0;
    endcase
  end

  assign isMulOp = (alu_op == 4'd10);
  assign isDivOp = (alu_op == 4'd11);
  assign aNeg    = yReg[DATA_W-1];
  assign bNeg    = busVal[DATA_W-1];
  assign magA    = aNeg ? -yReg : yReg;
  assign magB    = bNeg ? -busVal : busVal;

  assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
  assign remShift = {accHi, accLo[DATA_W-1]};
  assign diff     = remShift - {1'b0, opB};

  always_comb begin
    mulSigned = resNeg ? -{accHi, accLo} : {accHi, accLo};
    fixHi = '0;
    fixLo = '0;
    if (mulOp) begin
      {fixHi, fixLo} = mulSigned;
    end else if (divZero) begin
      fixLo = '1;
      fixHi = accHi;
    end else begin
      fixLo = resNeg ? -accLo : accLo;
      fixHi = remNeg ? -accHi : accHi;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    finish    = 1'b0;
    alu_busy  = (state != IDLE);
    case (state)
      IDLE: if (alu_start) begin
        accept = 1'b1;
        if (isMulOp)      nextState = ITER;
        else if (isDivOp) nextState = (busVal == '0) ? FIX : ITER;
      end
      ITER: if (cnt == '0) nextState = FIX;
      FIX: begin
        finish    = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      zHi <= '0; zLo <= '0; accHi <= '0; accLo <= '0; opB <= '0; cnt <= '0;
      mulOp <= 1'b0; resNeg <= 1'b0; remNeg <= 1'b0; divZero <= 1'b0; alu_done <= 1'b0;
    end else begin
      alu_done <= 1'b0;
      if (accept) begin
        if (isMulOp || isDivOp) begin
          mulOp   <= isMulOp;
          divZero <= isDivOp && (busVal == '0);
          // divide-by-zero parks the raw dividend where FIX expects the remainder
          accHi   <= (isDivOp && busVal == '0) ? yReg : '0;
          accLo   <= magA;
          opB     <= magB;
          resNeg  <= aNeg ^ bNeg;
          remNeg  <= aNeg;
          cnt     <= CNT_W'(DATA_W - 1);
        end else begin
          zLo      <= simpleRes;
          zHi      <= '0;
          alu_done <= 1'b1;
        end
      end
      if (state == ITER) begin
        cnt <= cnt - CNT_W'(1);
        if (mulOp) begin
          accHi <= mulSum[DATA_W:1];
          accLo <= {mulSum[0], accLo[DATA_W-1:1]};
        end else if (!diff[DATA_W]) begin
          accHi <= diff[DATA_W-1:0];
          accLo <= {accLo[DATA_W-2:0], 1'b1};
        end else begin
          accHi <= remShift[DATA_W-1:0];
          accLo <= {accLo[DATA_W-2:0], 1'b0};
        end
      end
      if (finish) begin
        zHi      <= fixHi;
        zLo      <= fixLo;
        alu_done <= 1'b1;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (accept && !isMulOp && !isDivOp) begin
      flag_z <= (simpleRes == '0);
      flag_n <= simpleRes[DATA_W-1];
    end else if (finish) begin
      flag_z <= mulOp ? ({fixHi, fixLo} == '0) : (fixLo == '0);
      flag_n <= mulOp ? fixHi[DATA_W-1] : fixLo[DATA_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_seq_datapath;
  localparam int W = 32;
  localparam int N = 16;
  localparam logic [4:0] S_HI = 5'd16, S_LO = 5'd17, S_ZHI = 5'd18, S_ZLO = 5'd19;
  localparam logic [4:0] S_PC = 5'd20, S_MDR = 5'd21, S_IN = 5'd22;

  logic clock, clear;
  logic [4:0] bus_sel;
  logic ba_out, reg_wr, y_in, hi_in, lo_in, pc_in, out_in, mdr_in, mdr_read, in_strobe, alu_start;
  logic [3:0] reg_wr_sel, alu_op;
  logic [W-1:0] mem_data_in, in_data, bus_out, out_data;
  logic alu_busy, alu_done;
`ifdef ALU_FLAGS_EN
  logic flag_z, flag_n;
`endif

  seq_datapath dut (
    .clock(clock), .clear(clear), .bus_sel(bus_sel), .ba_out(ba_out), .reg_wr(reg_wr),
    .reg_wr_sel(reg_wr_sel), .y_in(y_in), .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in),
    .out_in(out_in), .mdr_in(mdr_in), .mdr_read(mdr_read), .mem_data_in(mem_data_in),
    .in_strobe(in_strobe), .in_data(in_data), .alu_op(alu_op), .alu_start(alu_start),
    .alu_busy(alu_busy), .alu_done(alu_done), .bus_out(bus_out),
`ifdef ALU_FLAGS_EN
    .flag_z(flag_z), .flag_n(flag_n),
`endif
    .out_data(out_data));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0, passed = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // reference state
  logic [31:0] mR [N];
  logic [31:0] mHi, mLo, mPc, mMdr, mY, mZhi, mZlo, mIn, mOut, mB;
  logic [63:0] mPend, mRes;
  int mLeft;
  bit mDone, mPendMul, mFz, mFn;

  function automatic logic [31:0] modelBus(input logic [4:0] sel, input logic ba);
    if (sel < 5'd16) return (sel == 5'd0 && ba) ? 32'd0 : mR[sel[3:0]];
    case (sel)
      S_HI: return mHi;
      S_LO: return mLo;
      S_ZHI: return mZhi;
      S_ZLO: return mZlo;
      S_PC: return mPc;
      S_MDR: return mMdr;
      S_IN: return mIn;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] dbl;
    longint sa, sb, q, r;
    int sh;
    sh = int'(b[4:0]);
    dbl = {a, a};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: return {32'd0, a + b};
      4'd1: return {32'd0, a - b};
      4'd2: return {32'd0, a & b};
      4'd3: return {32'd0, a | b};
      4'd4: return {32'd0, a >> sh};
      4'd5: return {32'd0, a << sh};
      4'd6: begin dbl = dbl >> sh; return {32'd0, dbl[31:0]}; end
      4'd7: begin dbl = dbl << sh; return {32'd0, dbl[63:32]}; end
      4'd8: return {32'd0, 32'd0 - b};
      4'd9: return {32'd0, ~b};
      4'd10: begin q = sa * sb; return q; end
      4'd11: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic setFlags(input bit isMul, input logic [63:0] res);
    mFz = isMul ? (res == 64'd0) : (res[31:0] == 32'd0);
    mFn = isMul ? res[63] : res[31];
  endtask

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < N; i++) mR[i] = 32'd0;
      mHi = 0; mLo = 0; mPc = 0; mMdr = 0; mY = 0; mZhi = 0; mZlo = 0; mIn = 0; mOut = 0;
      mLeft = 0; mDone = 0; mFz = 0; mFn = 0;
    end else begin
      mB = modelBus(bus_sel, ba_out);
      mDone = 0;
      if (mLeft > 0) begin
        mLeft--;
        if (mLeft == 0) begin
          {mZhi, mZlo} = mPend;
          setFlags(mPendMul, mPend);
          mDone = 1;
        end
      end else if (alu_start) begin
        mRes = aluRef(alu_op, mY, mB);
        if (alu_op == 4'd10 || alu_op == 4'd11) begin
          mPend = mRes;
          mPendMul = (alu_op == 4'd10);
          mLeft = (alu_op == 4'd11 && mB == 32'd0) ? 1 : W + 1;
        end else begin
          {mZhi, mZlo} = mRes;
          setFlags(1'b0, mRes);
          mDone = 1;
        end
      end
      if (reg_wr) mR[reg_wr_sel] = mB;
      if (y_in) mY = mB;
      if (hi_in) mHi = mB;
      if (lo_in) mLo = mB;
      if (pc_in) mPc = mB;
      if (out_in) mOut = mB;
      if (mdr_in) mMdr = mdr_read ? mem_data_in : mB;
      if (in_strobe) mIn = in_data;
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      chk("bus_out", bus_out, modelBus(bus_sel, ba_out));
      chk("out_data", out_data, mOut);
      chk("alu_busy", 32'(alu_busy), 32'(mLeft > 0));
      chk("alu_done", 32'(alu_done), 32'(mDone));
`ifdef ALU_FLAGS_EN
      chk("flag_z", 32'(flag_z), 32'(mFz));
      chk("flag_n", 32'(flag_n), 32'(mFn));
`endif
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic idleInputs();
    reg_wr = 0; y_in = 0; hi_in = 0; lo_in = 0; pc_in = 0; out_in = 0;
    mdr_in = 0; in_strobe = 0; alu_start = 0; ba_out = 0;
  endtask

  task automatic startOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_data = a; in_strobe = 1; step(); in_strobe = 0;
    bus_sel = S_IN; y_in = 1; step(); y_in = 0;
    in_data = b; in_strobe = 1; step(); in_strobe = 0;
    alu_op = op; alu_start = 1; step(); alu_start = 0;
  endtask

  task automatic waitDone(input logic [3:0] op, input bit disturb, output int lat, output int busyN);
    lat = 1;
    busyN = 0;
    while (!alu_done && lat < 200) begin
      if (alu_busy) busyN++;
      if (disturb && lat == 10) begin
        alu_start = 1; alu_op = 4'd0; in_data = 32'h5555_5555; in_strobe = 1;
      end
      if (disturb && lat == 12) y_in = 1;
      step();
      alu_start = 0; in_strobe = 0; y_in = 0; alu_op = op;
      lat++;
    end
    chk("alu_done_seen", 32'(alu_done), 32'd1);
  endtask

  task automatic readZ(input string name, input logic [31:0] expHi, input logic [31:0] expLo);
    bus_sel = S_ZHI; #1; chk({name, "_zhi"}, bus_out, expHi);
    bus_sel = S_ZLO; #1; chk({name, "_zlo"}, bus_out, expLo);
  endtask

  int lat, busyN;

  initial begin
    idleInputs();
    bus_sel = S_IN; reg_wr_sel = 0; mdr_read = 0; mem_data_in = 0; in_data = 0; alu_op = 0;
    clear = 1;
    #3 clear = 0;
    checking = 1;
    step();
    chk("rst_bus_in", bus_out, 32'd0);
    chk("rst_out", out_data, 32'd0);
    chk("rst_busy", 32'(alu_busy), 32'd0);
    chk("rst_done", 32'(alu_done), 32'd0);
    clear = 1;
    step();

    // R5 through INPORT, then R0 masking
    in_data = 32'h0000_00A5; in_strobe = 1; step(); in_strobe = 0;
    bus_sel = S_IN; reg_wr = 1; reg_wr_sel = 4'd5; step(); reg_wr = 0;
    bus_sel = 5'd5; #1; chk("r5_read", bus_out, 32'h0000_00A5);
    in_data = 32'h0000_1234; in_strobe = 1; step(); in_strobe = 0;
    bus_sel = S_IN; reg_wr = 1; reg_wr_sel = 4'd0; step(); reg_wr = 0;
    bus_sel = 5'd0; ba_out = 1; #1; chk("r0_masked", bus_out, 32'd0);
    ba_out = 0; #1; chk("r0_read", bus_out, 32'h0000_1234);

    // MDR both sources and output port
    mem_data_in = 32'hDEAD_BEEF; mdr_in = 1; mdr_read = 1; step(); mdr_in = 0;
    bus_sel = S_MDR; #1; chk("mdr_mem", bus_out, 32'hDEAD_BEEF);
    bus_sel = 5'd5; mdr_in = 1; mdr_read = 0; out_in = 1; step(); mdr_in = 0; out_in = 0;
    bus_sel = S_MDR; #1; chk("mdr_bus", bus_out, 32'h0000_00A5);
    chk("out_port", out_data, 32'h0000_00A5);

    startOp(4'd0, 32'd7, 32'd3); waitDone(4'd0, 0, lat, busyN);
    chk("add_lat", lat, 1); readZ("add", 32'd0, 32'd10);
    startOp(4'd1, 32'd3, 32'd7); waitDone(4'd1, 0, lat, busyN);
    readZ("sub", 32'd0, 32'hFFFF_FFFC);

    startOp(4'd10, 32'hFFFF_FFFA, 32'd7); waitDone(4'd10, 1, lat, busyN);
    chk("mul_lat", lat, 34); chk("mul_busy", busyN, 33);
    readZ("mul", 32'hFFFF_FFFF, 32'hFFFF_FFD6);

    startOp(4'd11, 32'hFFFF_FFEF, 32'd5); waitDone(4'd11, 0, lat, busyN);
    chk("div_lat", lat, 34); readZ("div", 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    startOp(4'd11, 32'd9, 32'd0); waitDone(4'd11, 0, lat, busyN);
    chk("div0_lat", lat, 2); readZ("div0", 32'd9, 32'hFFFF_FFFF);

    // abandon a multiply mid-flight
    startOp(4'd10, 32'hFFFF_FFFA, 32'd7);
    repeat (14) step();
    chk("mid_mul_busy", 32'(alu_busy), 32'd1);
    clear = 0; #1;
    chk("clr_busy", 32'(alu_busy), 32'd0);
    readZ("clr", 32'd0, 32'd0);
    step(); clear = 1; step();
    startOp(4'd0, 32'd7, 32'd3); waitDone(4'd0, 0, lat, busyN);
    chk("add2_lat", lat, 1); readZ("add2", 32'd0, 32'd10);

    startOp(4'd6, 32'h8000_0001, 32'd1); waitDone(4'd6, 0, lat, busyN);
    readZ("ror", 32'd0, 32'hC000_0000);
`ifdef ALU_FLAGS_EN
    chk("ror_fn", 32'(flag_n), 32'd1); chk("ror_fz", 32'(flag_z), 32'd0);
`endif
    startOp(4'd2, 32'h0000_00F0, 32'h0000_000F); waitDone(4'd2, 0, lat, busyN);
    readZ("and", 32'd0, 32'd0);
`ifdef ALU_FLAGS_EN
    chk("and_fz", 32'(flag_z), 32'd1);
`endif

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      bus_sel = 5'($urandom_range(0, 31));
      ba_out = ($urandom_range(0, 3) == 0);
      reg_wr = ($urandom_range(0, 2) == 0);
      reg_wr_sel = 4'($urandom);
      y_in = ($urandom_range(0, 3) == 0);
      hi_in = ($urandom_range(0, 5) == 0);
      lo_in = ($urandom_range(0, 5) == 0);
      pc_in = ($urandom_range(0, 5) == 0);
      out_in = ($urandom_range(0, 5) == 0);
      mdr_in = ($urandom_range(0, 5) == 0);
      mdr_read = 1'($urandom);
      mem_data_in = $urandom;
      in_strobe = ($urandom_range(0, 1) == 0);
      in_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      alu_op = 4'($urandom);
      alu_start = ($urandom_range(0, 5) == 0);
      step();
    end
    idleInputs();
    step();
    checking = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seq_datapath.md
Name: seq_datapath

Overview:
- Parametrised next-generation bus datapath for the mini CPU.
- Contains a general register bank of NUM_REGS x DATA_W, plus HI, LO, PC, MDR, Y, Z pair, input port and output port, all on one shared bus.
- One-hot out/in strobes are replaced by encoded source/destination selects.
- Adds a sequenced ALU with a start/busy/done handshake and iterative signed multiply/divide, so the control unit can issue multi-cycle operations.

Parameters:
- DATA_W, 32, width of bus, registers and ALU operands.
- NUM_REGS, 16, number of general registers R0..R(NUM_REGS-1); minimum 2.
- SEL_W, clog2(NUM_REGS+7), width of the encoded bus source select.
- RSEL_W, clog2(NUM_REGS), width of the general register write select.

Ports:
- clock, in, 1, rising-edge clock.
- clear, in, 1, asynchronous active-low reset.
- bus_sel, in, SEL_W, bus source.
  - 0..NUM_REGS-1 = R0..Rn.
  - NUM_REGS+0..6 = HI, LO, ZHI, ZLO, PC, MDR, INPORT.
  - Any other code drives 0.
- ba_out, in, 1, when 1 and bus_sel=0 the bus carries 0 instead of R0.
- reg_wr, in, 1, write the bus into the general register selected by reg_wr_sel.
- reg_wr_sel, in, RSEL_W, destination general register.
- y_in, hi_in, lo_in, pc_in, out_in, in, 1 each, load the named register from the bus.
- mdr_in, in, 1, load MDR.
- mdr_read, in, 1, MDR load source: 1 = mem_data_in, 0 = bus.
- mem_data_in, in, DATA_W, memory read data.
- in_strobe, in, 1, latch in_data into INPORT.
- in_data, in, DATA_W, external input.
- alu_op, in, 4, ALU operation.
- alu_start, in, 1, start the ALU with A=Y and B=bus.
- alu_busy, out, 1, ALU sequencing.
- alu_done, out, 1, one-cycle pulse when Z has been written.
- bus_out, out, DATA_W, current bus value (combinational).
- out_data, out, DATA_W, output port register.

Behaviour:
- Reset (clear=0, asynchronous):
  - All registers, Z pair, INPORT and out_data go to 0.
  - alu_busy=0, alu_done=0; FSM returns to IDLE.
  - An in-flight mul/div is abandoned and Z is not written.
- Bus is combinational from bus_sel; all register loads take effect at the next rising edge.
- Multiple load enables in the same cycle all capture the same bus value.
- R0 is writable; ba_out masks R0 only on reads.
- ALU opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR.
  - 4 SHR logical, 5 SHL, 6 ROR, 7 ROL; shift amount = B[clog2(DATA_W)-1:0].
  - 8 NEG(B), 9 NOT(B).
  - 10 MUL signed, 11 DIV signed.
  - 12-15: Z=0, treated as single-cycle.
  - Single-cycle ops: ZLO=result, ZHI=0.
- FSM states: IDLE, ITER, FIX.
- IDLE:
  - alu_start=1 latches A, B and op.
  - Single-cycle op: Z written at the same edge; alu_done=1 the following cycle; stays in IDLE.
  - MUL/DIV: operands converted to magnitude, sign recorded, go to ITER, alu_busy=1.
- ITER:
  - Runs exactly DATA_W cycles of shift-add (MUL) or restoring shift-subtract (DIV), then goes to FIX.
- FIX:
  - Applies signs and writes Z.
  - MUL: {ZHI,ZLO} = 2*DATA_W-bit signed product.
  - DIV: ZLO = quotient truncated toward zero; ZHI = remainder with the dividend's sign.
  - Returns to IDLE; alu_busy=0 and alu_done=1 in the next cycle.
  - Total: alu_done is seen DATA_W+2 cycles after the start edge.
- Divide by zero: skips ITER; FIX writes ZLO = all ones, ZHI = dividend. Latency is 2 cycles.
- alu_start while alu_busy=1 is ignored; operands are unchanged.
- alu_start in the same cycle alu_done=1 is accepted.
- Y may be reloaded during ITER without affecting the operation.
- MDR: mdr_in with mdr_read=1 takes mem_data_in; with mdr_read=0 it takes the bus.
- INPORT loads on every edge where in_strobe=1.

Optional Feature:
ALU_FLAGS_EN
- Defined:
  - Adds outputs flag_z (ZLO==0, or {ZHI,ZLO}==0 for MUL) and flag_n (MSB of ZLO for single-cycle/DIV, MSB of ZHI for MUL).
  - Flags are registered at the same edge as Z and reset to 0.
  - Divide by zero sets flag_z=0, flag_n=1.
- Undefined: the ports are absent and there is no flag logic.

Test Plan:
- Reset, then write R5=0x0000_00A5 via bus_sel=INPORT (in_data strobed) and reg_wr_sel=5; read bus_sel=5 -> bus_out=0x0000_00A5. Then bus_sel=0 with ba_out=1 -> bus_out=0 while R0=0x1234 is held.
- Y=7, B=3, ADD -> alu_done 1 cycle after start, ZLO=10, ZHI=0. SUB with Y=3, B=7 -> ZLO=0xFFFF_FFFC.
- MUL Y=-6 (0xFFFF_FFFA), B=7:
  - alu_busy high for 33 cycles.
  - alu_done at cycle 34 after start.
  - ZHI=0xFFFF_FFFF, ZLO=0xFFFF_FFD6.
  - An alu_start issued at cycle 10 is ignored.
- DIV Y=-17, B=5 -> ZLO=-3 (0xFFFF_FFFD), ZHI=-2. DIV Y=9, B=0 -> done after 2 cycles, ZLO=0xFFFF_FFFF, ZHI=9.
- Assert clear at cycle 15 of a MUL -> alu_busy=0 immediately and Z=0. A new ADD after release completes normally.
- ROR Y=0x8000_0001, B=1 -> ZLO=0xC000_0000. With ALU_FLAGS_EN: flag_n=1, flag_z=0. AND Y=0xF0, B=0x0F -> flag_z=1.
